// File: rtl/c_instr_queue_pkg.sv
// Shared types and constants for the instruction queue that sits between the
// C-extension expander and the decode stage.
package c_instr_queue_pkg;

  localparam int unsigned IQ_DEPTH_DEFAULT = 4;

  // addi x0, x0, 0 -- presented to decode whenever the queue has nothing valid.
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_comp;
    logic        illegal;
  } type_iq_entry_s;

endpackage

// File: rtl/c_instr_queue.sv
// Small circular FIFO of expanded instructions; flush discards everything,
// head entry is read combinationally with a NOP when nothing is valid.
module c_instr_queue
  import c_instr_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  input  logic [31:0]                enq_instr_i,
  input  logic [31:0]                enq_pc_i,
  input  logic                       enq_is_comp_i,
  input  logic                       enq_illegal_i,
  output logic                       enq_ready_o,
  output logic                       deq_valid_o,
  output logic [31:0]                deq_instr_o,
  output logic [31:0]                deq_pc_o,
  output logic                       deq_is_comp_o,
  output logic                       deq_illegal_o,
  output logic [31:0]                deq_pc_next_o,
  input  logic                       deq_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  type_iq_entry_s mem_q [DEPTH];
  type_iq_entry_s head_entry;

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic full, empty, do_enq, do_deq;

  // Full/empty come from the count so head == tail is never ambiguous.
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  assign enq_ready_o = !full && !flush_i;
  assign deq_valid_o = !empty && !flush_i;
  assign do_enq      = enq_valid_i && enq_ready_o;
  assign do_deq      = deq_valid_o && deq_ready_i;
  assign count_o     = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) tail_d = tail_q + PtrW'(1);
      if (do_deq) head_d = head_q + PtrW'(1);
      unique case ({do_enq, do_deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; stale slots are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem_q[tail_q] <= '{instr:   enq_instr_i,
                         pc:      enq_pc_i,
                         is_comp: enq_is_comp_i,
                         illegal: enq_illegal_i};
    end
  end

  assign head_entry = mem_q[head_q];

  always_comb begin
    deq_instr_o   = NOP;
    deq_pc_o      = '0;
    deq_is_comp_o = 1'b0;
    deq_illegal_o = 1'b0;
    deq_pc_next_o = '0;
    if (deq_valid_o) begin
      deq_instr_o   = head_entry.instr;
      deq_pc_o      = head_entry.pc;
      deq_is_comp_o = head_entry.is_comp;
      deq_illegal_o = head_entry.illegal;
      deq_pc_next_o = head_entry.pc + (head_entry.is_comp ? 32'd2 : 32'd4);
    end
  end

endmodule
